// File: rtl/dpram_loader.sv
// dpram_loader: byte-serial download / fill write engine for a dpram port B.
// Download bytes are packed into RAM words, queued in a small FIFO and
// written to sequential addresses from a programmable base. Fill mode writes
// one value to every RAM location. Every output is a register.
module dpram_loader #(
    parameter int DATA_WIDTH = 8,   // 8 or 16
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4    // power of two, >= 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  fill,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DATA_WIDTH-1:0] fill_value,
    input  logic                  dl_valid,
    input  logic [7:0]            dl_data,
    input  logic                  dl_last,
    output logic                  dl_ready,
    input  logic                  hold,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [7:0]            checksum,
    output logic                  overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WC_W  = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FILL, S_DONE} state_t;

    state_t state_q, state_d;

    // Output registers
    logic                  dl_ready_q, dl_ready_d;
    logic                  ram_wren_q, ram_wren_d;
    logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
    logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [WC_W-1:0]       word_count_q, word_count_d;
    logic [7:0]            checksum_q, checksum_d;
    logic                  overflow_q, overflow_d;

    // Session datapath
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;         // next write address
    logic                  last_seen_q, last_seen_d; // source exhausted
    logic [DATA_WIDTH-1:0] fill_value_q, fill_value_d;

    // Word FIFO
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  session_start;
    logic                  accept;
    logic                  pop;
    logic                  fill_issue;
    logic                  issue;
    logic                  push;
    logic [DATA_WIDTH-1:0] push_word;

    assign session_start = (state_q == S_IDLE) && (start || fill);
    assign accept        = (state_q == S_LOAD) && dl_valid && dl_ready_q;
    assign pop           = (state_q == S_LOAD) && (count_q != '0) && !hold;
    assign fill_issue    = (state_q == S_FILL) && !last_seen_q && !hold;
    assign issue         = pop || fill_issue;

    // Byte-to-word packing; 16-bit words are little-endian with a zero pad
    // when the stream ends on a low byte.
    if (DATA_WIDTH == 8) begin : g_pack8
        assign push      = accept;
        assign push_word = dl_data;
    end else begin : g_pack16
        logic       phase_q, phase_d;
        logic [7:0] lo_q, lo_d;

        // Track which half of the word the next byte fills
        always_comb begin
            phase_d = phase_q;
            lo_d    = lo_q;
            if (session_start) begin
                phase_d = 1'b0;
                lo_d    = '0;
            end else if (accept) begin
                if (!phase_q && !dl_last) begin
                    phase_d = 1'b1;
                    lo_d    = dl_data;
                end else begin
                    phase_d = 1'b0;
                end
            end
        end

        // Packing phase register
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                phase_q <= 1'b0;
                lo_q    <= '0;
            end else begin
                phase_q <= phase_d;
                lo_q    <= lo_d;
            end
        end

        assign push      = accept && (phase_q || dl_last);
        assign push_word = phase_q ? {dl_data, lo_q} : {8'h00, dl_data};
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start wins over fill; requests are only seen in IDLE
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end else if (fill) begin
                    state_d = S_FILL;
                end
            end
            S_LOAD:  if (last_seen_q && (count_q == '0)) state_d = S_DONE;
            S_FILL:  if (last_seen_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Session datapath and write-issue next values
    always_comb begin
        addr_d        = addr_q;
        word_count_d  = word_count_q;
        checksum_d    = checksum_q;
        overflow_d    = overflow_q;
        last_seen_d   = last_seen_q;
        fill_value_d  = fill_value_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        ram_wren_d    = issue;
        ram_address_d = issue ? addr_q : ram_address_q;
        ram_data_d    = ram_data_q;
        if (pop) begin
            ram_data_d = fifo_mem[rd_ptr_q];
        end else if (fill_issue) begin
            ram_data_d = fill_value_q;
        end

        if (session_start) begin
            addr_d       = start ? base_addr : '0;
            fill_value_d = fill_value;
            word_count_d = '0;
            checksum_d   = '0;
            overflow_d   = 1'b0;
            last_seen_d  = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
        end else begin
            if (accept) begin
                checksum_d = checksum_q + dl_data;
                if (dl_last) begin
                    last_seen_d = 1'b1;
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            // Full is judged after a simultaneous pop
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (issue) begin
                addr_d       = addr_q + ADDR_WIDTH'(1);
                word_count_d = word_count_q + WC_W'(1);
                if (addr_q == ADDR_MAX) begin
                    // A load wrap is reported; a fill wrap ends the sweep
                    if (pop) begin
                        overflow_d = 1'b1;
                    end else begin
                        last_seen_d = 1'b1;
                    end
                end
            end
        end
    end

    // Status outputs derived from the next state
    always_comb begin
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        dl_ready_d = (state_d == S_LOAD) && !last_seen_d && (count_d < FULL_CNT);
    end

    // NOTE: FIFO storage is not reset; the pointers and count say which entries are valid, so it maps onto plain RAM cells.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_word;
        end
    end

    // Output and datapath registers
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            dl_ready_q    <= 1'b0;
            ram_wren_q    <= 1'b0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            word_count_q  <= '0;
            checksum_q    <= '0;
            overflow_q    <= 1'b0;
            addr_q        <= '0;
            last_seen_q   <= 1'b0;
            fill_value_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            dl_ready_q    <= dl_ready_d;
            ram_wren_q    <= ram_wren_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            word_count_q  <= word_count_d;
            checksum_q    <= checksum_d;
            overflow_q    <= overflow_d;
            addr_q        <= addr_d;
            last_seen_q   <= last_seen_d;
            fill_value_q  <= fill_value_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    assign dl_ready    = dl_ready_q;
    assign ram_wren    = ram_wren_q;
    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign word_count  = word_count_q;
    assign checksum    = checksum_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_dpram_loader.sv
// Testbench for dpram_loader: an 8-bit/1K instance and a 16-bit/16-word
// instance, checked against a session-level model of the expected writes.
module tb_dpram_loader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, hold, dl_valid, dl_last;
    logic [7:0]  dl_data;
    logic        start_a, fill_a, start_b, fill_b;
    logic [9:0]  base_a;
    logic [7:0]  fillv_a;
    logic [3:0]  base_b;
    logic [15:0] fillv_b;

    logic        dl_ready_a, ram_wren_a, busy_a, done_a, overflow_a;
    logic [9:0]  ram_address_a;
    logic [7:0]  ram_data_a, checksum_a;
    logic [10:0] word_count_a;
    logic        dl_ready_b, ram_wren_b, busy_b, done_b, overflow_b;
    logic [3:0]  ram_address_b;
    logic [15:0] ram_data_b;
    logic [7:0]  checksum_b;
    logic [4:0]  word_count_b;

    dpram_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .FIFO_DEPTH(4)) u_a (
        .clock(clock), .reset_n(reset_n), .start(start_a), .fill(fill_a),
        .base_addr(base_a), .fill_value(fillv_a), .dl_valid(dl_valid),
        .dl_data(dl_data), .dl_last(dl_last), .dl_ready(dl_ready_a), .hold(hold),
        .ram_wren(ram_wren_a), .ram_address(ram_address_a), .ram_data(ram_data_a),
        .busy(busy_a), .done(done_a), .word_count(word_count_a),
        .checksum(checksum_a), .overflow(overflow_a)
    );

    dpram_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FIFO_DEPTH(4)) u_b (
        .clock(clock), .reset_n(reset_n), .start(start_b), .fill(fill_b),
        .base_addr(base_b), .fill_value(fillv_b), .dl_valid(dl_valid),
        .dl_data(dl_data), .dl_last(dl_last), .dl_ready(dl_ready_b), .hold(hold),
        .ram_wren(ram_wren_b), .ram_address(ram_address_b), .ram_data(ram_data_b),
        .busy(busy_b), .done(done_b), .word_count(word_count_b),
        .checksum(checksum_b), .overflow(overflow_b)
    );

    typedef struct {
        bit sel;
        int addr;
        int data;
        int cyc;
    } wr_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    bit         sel_b = 1'b0;
    wr_t        wq[$];
    int         acc_edge[$];
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         done_nobusy = 0;
    logic [7:0] stream[$];
    int         sidx = 0;

    logic cur_ready;
    int   cur_wc, cur_cs, cur_ovf, cur_busy;
    assign cur_ready = sel_b ? dl_ready_b : dl_ready_a;
    assign cur_wc    = sel_b ? int'(word_count_b) : int'(word_count_a);
    assign cur_cs    = sel_b ? int'(checksum_b) : int'(checksum_a);
    assign cur_ovf   = sel_b ? int'(overflow_b) : int'(overflow_a);
    assign cur_busy  = sel_b ? int'(busy_b) : int'(busy_a);

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: record writes, done pulses and byte acceptances mid-cycle
    always @(negedge clock) begin
        if (ram_wren_a) wq.push_back('{sel: 1'b0, addr: int'(ram_address_a), data: int'(ram_data_a), cyc: cyc});
        if (ram_wren_b) wq.push_back('{sel: 1'b1, addr: int'(ram_address_b), data: int'(ram_data_b), cyc: cyc});
        if (done_a || done_b) begin
            done_cnt++;
            done_cyc = cyc;
            if (!(done_a ? busy_a : busy_b)) done_nobusy++;
        end
        if (dl_valid && cur_ready) acc_edge.push_back(cyc + 1);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic new_stream(input int n);
        stream.delete();
        for (int i = 0; i < n; i++) stream.push_back(8'($urandom));
    endtask

    task automatic begin_session(input bit b, input bit do_start, input bit do_fill,
                                 input int base, input int fv, output int edge_no);
        sel_b = b;
        wq.delete();
        acc_edge.delete();
        done_cnt = 0;
        done_cyc = -1;
        done_nobusy = 0;
        sidx = 0;
        if (b) begin
            start_b = do_start; fill_b = do_fill; base_b = base[3:0]; fillv_b = fv[15:0];
        end else begin
            start_a = do_start; fill_a = do_fill; base_a = base[9:0]; fillv_a = fv[7:0];
        end
        edge_no = cyc + 1;
        tick();
        start_a = 1'b0; fill_a = 1'b0; start_b = 1'b0; fill_b = 1'b0;
    endtask

    // Offer stream bytes from sidx on for at most max_cycles cycles
    task automatic drive_stream(input int max_cycles, input int hold_cycles,
                                input int valid_pct, input int hold_pct);
        int guard;
        int n;
        bit v;
        guard = 0;
        n = stream.size();
        while (sidx < n && guard < max_cycles) begin
            v = ($urandom_range(99) < valid_pct);
            hold = (guard < hold_cycles) ? 1'b1 : ($urandom_range(99) < hold_pct);
            dl_valid = v;
            dl_data = stream[sidx];
            dl_last = (sidx == n - 1);
            if (v && cur_ready) sidx++;
            guard++;
            tick();
        end
        dl_valid = 1'b0;
        dl_last = 1'b0;
        hold = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit, input int hold_pct);
        int guard;
        guard = 0;
        while (done_cnt == 0 && guard < limit) begin
            hold = ($urandom_range(99) < hold_pct);
            guard++;
            tick();
        end
        hold = 1'b0;
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s done_timeout: got no done in %0d cycles, required one", name, limit);
        end
        tick();
        tick();
    endtask

    // Compare one finished session with the writes implied by the stream
    task automatic verify_session(input string name, input bit b, input int base,
                                  input bit is_fill, input int fv);
        int mod, csum, n, bad, exp_addr;
        int exp_w[$];
        bit exp_ovf;
        mod = b ? 16 : 1024;
        csum = 0;
        n = stream.size();
        if (is_fill) begin
            for (int i = 0; i < mod; i++) exp_w.push_back(fv);
        end else begin
            for (int i = 0; i < n; i++) csum += int'(stream[i]);
            csum = csum % 256;
            if (!b) begin
                for (int i = 0; i < n; i++) exp_w.push_back(int'(stream[i]));
            end else begin
                for (int i = 0; i < n; i += 2)
                    exp_w.push_back(int'(stream[i]) + ((i + 1 < n) ? int'(stream[i+1]) * 256 : 0));
            end
        end
        exp_ovf = !is_fill && (base + exp_w.size() >= mod);

        checks++;
        if (wq.size() != exp_w.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d required %0d", name, wq.size(), exp_w.size());
        end
        checks++;
        bad = 0;
        for (int i = 0; i < wq.size() && i < exp_w.size(); i++) begin
            exp_addr = (base + i) % mod;
            if (wq[i].sel != b || wq[i].addr != exp_addr || wq[i].data != exp_w[i]) begin
                if (bad == 0)
                    $display("FAIL %s write[%0d]: got sel=%0d addr=%h data=%h required sel=%0d addr=%h data=%h",
                             name, i, wq[i].sel, wq[i].addr, wq[i].data, b, exp_addr, exp_w[i]);
                bad++;
            end
        end
        if (bad != 0) errors++;
        checks++;
        if (cur_wc != exp_w.size()) begin
            errors++;
            $display("FAIL %s word_count: got %0d required %0d", name, cur_wc, exp_w.size());
        end
        checks++;
        if (cur_cs != csum) begin
            errors++;
            $display("FAIL %s checksum: got %h required %h", name, cur_cs, csum);
        end
        checks++;
        if (cur_ovf != int'(exp_ovf)) begin
            errors++;
            $display("FAIL %s overflow: got %0d required %0d", name, cur_ovf, exp_ovf);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d required 1", name, done_cnt);
        end
        checks++;
        if (wq.size() > 0 && done_cyc != wq[wq.size()-1].cyc + 1) begin
            errors++;
            $display("FAIL %s done_timing: got cycle %0d required %0d", name, done_cyc, wq[wq.size()-1].cyc + 1);
        end
        checks++;
        if (done_nobusy != 0 || cur_busy != 0) begin
            errors++;
            $display("FAIL %s busy: got done-without-busy=%0d busy-after=%0d required 0 and 0", name, done_nobusy, cur_busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({dl_ready_a, ram_wren_a, busy_a, done_a, overflow_a, ram_address_a, ram_data_a, word_count_a, checksum_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: got nonzero outputs ready=%b wren=%b busy=%b wc=%h cs=%h required all 0", dl_ready_a, ram_wren_a, busy_a, word_count_a, checksum_a);
        end
        checks++;
        if ({dl_ready_b, ram_wren_b, busy_b, done_b, overflow_b, ram_address_b, ram_data_b, word_count_b, checksum_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: got nonzero outputs ready=%b wren=%b busy=%b wc=%h cs=%h required all 0", dl_ready_b, ram_wren_b, busy_b, word_count_b, checksum_b);
        end
        reset_n = 1'b1;
        repeat (2) tick();
        checks++;
        if ({dl_ready_a, ram_wren_a, busy_a, done_a, dl_ready_b, ram_wren_b, busy_b, done_b} !== 8'h00) begin
            errors++;
            $display("FAIL idle_after_reset: got %b required 00000000", {dl_ready_a, ram_wren_a, busy_a, done_a, dl_ready_b, ram_wren_b, busy_b, done_b});
        end
    endtask

    task automatic test_load8_wrap();
        int e, bad;
        stream.delete();
        for (int i = 1; i <= 5; i++) stream.push_back(8'(i));
        begin_session(1'b0, 1'b1, 1'b0, 'h3FE, 0, e);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL load8 busy_rise: got %b required 1", busy_a);
        end
        drive_stream(100, 0, 100, 0);
        wait_done("load8", 100, 0);
        verify_session("load8", 1'b0, 'h3FE, 1'b0, 0);
        checks++;
        bad = 0;
        for (int i = 0; i < wq.size() && i < acc_edge.size(); i++)
            if (wq[i].cyc != acc_edge[i] + 1) bad++;
        if (bad != 0 || acc_edge.size() != 5) begin
            errors++;
            $display("FAIL load8 latency: got %0d late writes of %0d accepts required 0 of 5", bad, acc_edge.size());
        end
    endtask

    task automatic test_load16();
        int e;
        stream.delete();
        stream.push_back(8'h34); stream.push_back(8'h12); stream.push_back(8'h78);
        begin_session(1'b1, 1'b1, 1'b0, 3, 0, e);
        drive_stream(100, 0, 100, 0);
        wait_done("load16", 100, 0);
        verify_session("load16", 1'b1, 3, 1'b0, 0);
        checks++;
        if (wq.size() != 2 || acc_edge.size() != 3 ||
            wq[0].cyc != acc_edge[1] + 1 || wq[1].cyc != acc_edge[2] + 1) begin
            errors++;
            $display("FAIL load16 latency: got %0d writes %0d accepts required writes one cycle after the completing edge", wq.size(), acc_edge.size());
        end
    endtask

    task automatic test_hold_backpressure();
        int e;
        new_stream(10);
        begin_session(1'b0, 1'b1, 1'b0, $urandom_range(1023), 0, e);
        drive_stream(8, 8, 100, 0);
        checks++;
        if (sidx != 4 || dl_ready_a !== 1'b0 || wq.size() != 0) begin
            errors++;
            $display("FAIL hold_stall: got accepted=%0d ready=%b writes=%0d required 4, 0, 0", sidx, dl_ready_a, wq.size());
        end
        drive_stream(200, 0, 100, 0);
        wait_done("hold", 200, 0);
        verify_session("hold", 1'b0, int'(base_a), 1'b0, 0);
    endtask

    task automatic test_fill();
        int e, fv;
        stream.delete();
        begin_session(1'b1, 1'b0, 1'b1, 0, 'hA5, e);
        wait_done("fill16", 100, 0);
        verify_session("fill16", 1'b1, 0, 1'b1, 'hA5);
        checks++;
        if (wq.size() != 16 || wq[0].cyc != e + 1 || wq[15].cyc != wq[0].cyc + 15) begin
            errors++;
            $display("FAIL fill16 timing: got %0d writes, first at %0d required 16 writes from %0d back to back", wq.size(), (wq.size() > 0) ? wq[0].cyc : -1, e + 1);
        end
        fv = $urandom_range(255);
        begin_session(1'b0, 1'b0, 1'b1, $urandom_range(1023), fv, e);
        wait_done("fill8_hold", 4000, 30);
        verify_session("fill8_hold", 1'b0, 0, 1'b1, fv);
    endtask

    task automatic test_priority();
        int e, base;
        base = $urandom_range(1023);
        new_stream(6);
        begin_session(1'b0, 1'b1, 1'b1, base, 'h5A, e);
        checks++;
        if (dl_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL priority ready: got %b required 1 (load session)", dl_ready_a);
        end
        drive_stream(3, 0, 100, 0);
        start_a = 1'b1; fill_a = 1'b1; base_a = ~base_a;
        tick();
        start_a = 1'b0; fill_a = 1'b0;
        drive_stream(200, 0, 100, 0);
        wait_done("priority", 200, 0);
        verify_session("priority", 1'b0, base, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        int e, rst_edge, late, base;
        new_stream(6);
        begin_session(1'b0, 1'b1, 1'b0, $urandom_range(1023), 0, e);
        drive_stream(2, 0, 100, 0);
        reset_n = 1'b0;
        rst_edge = cyc + 1;
        tick();
        reset_n = 1'b1;
        checks++;
        if ({dl_ready_a, ram_wren_a, busy_a, done_a, overflow_a, ram_address_a, ram_data_a, word_count_a, checksum_a} !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs: got ready=%b wren=%b busy=%b wc=%h cs=%h required all 0", dl_ready_a, ram_wren_a, busy_a, word_count_a, checksum_a);
        end
        repeat (6) tick();
        late = 0;
        foreach (wq[i]) if (wq[i].cyc >= rst_edge) late++;
        checks++;
        if (late != 0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid quiet: got %0d writes after reset, busy=%b required 0, 0", late, busy_a);
        end
        base = $urandom_range(1023);
        begin_session(1'b0, 1'b1, 1'b0, base, 0, e);
        drive_stream(200, 0, 100, 0);
        wait_done("reset_mid_reload", 200, 0);
        verify_session("reset_mid_reload", 1'b0, base, 1'b0, 0);
    endtask

    task automatic test_random_sessions();
        int e, base, vp, hp;
        bit b;
        string nm;
        for (int s = 0; s < 10; s++) begin
            b = s[0];
            base = b ? $urandom_range(15) : $urandom_range(1023);
            vp = $urandom_range(100, 40);
            hp = $urandom_range(50);
            new_stream($urandom_range(24, 1));
            nm = $sformatf("random%0d", s);
            begin_session(b, 1'b1, 1'b0, base, 0, e);
            drive_stream(2000, 0, vp, hp);
            checks++;
            if (sidx != stream.size()) begin
                errors++;
                $display("FAIL %s stream_stall: got %0d bytes accepted required %0d", nm, sidx, stream.size());
            end
            wait_done(nm, 500, hp);
            verify_session(nm, b, base, 1'b0, 0);
        end
    endtask

    initial begin
        reset_n = 1'b0; hold = 1'b0; dl_valid = 1'b0; dl_last = 1'b0; dl_data = '0;
        start_a = 1'b0; fill_a = 1'b0; start_b = 1'b0; fill_b = 1'b0;
        base_a = '0; fillv_a = '0; base_b = '0; fillv_b = '0;
        test_reset();
        test_load8_wrap();
        test_load16();
        test_hold_backpressure();
        test_fill();
        test_priority();
        test_reset_mid();
        test_random_sessions();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
